// File: rtl/attract_screen.sv
`default_nettype none
// ============================================================================
// Module   : attract_screen
// Purpose  : Attract-mode animator for the tile grid. While the game is idle
//            it drops tiles on pseudo-random cells, one step per
//            DELAY_FRAMES video frames. Modes: single hopping tile, hopping
//            tile with a counting value, and progressive fill-then-clear.
// Revision : 1.0 - initial release
// ============================================================================
module attract_screen #(
  parameter int GRID_CELLS   = 16,
  parameter int CELL_W       = 4,
  parameter int DELAY_FRAMES = 30,
  parameter int TILE_VALUE   = 11,
  parameter int IDX_W        = $clog2(GRID_CELLS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [1:0]                   mode,
  input  logic                         frame_tick,
  input  logic [IDX_W-1:0]             lfsr_in,
  output logic [GRID_CELLS*CELL_W-1:0] grid,
  output logic                         step,
  output logic [IDX_W-1:0]             tile_idx
);

  localparam int                CNT_W     = $clog2(DELAY_FRAMES + 1);
  localparam int                PAD_CELLS = 1 << IDX_W;
  localparam logic [CELL_W-1:0] TILE_V    = CELL_W'(TILE_VALUE);
  localparam logic [CELL_W-1:0] VAL_ONE   = CELL_W'(1);
  localparam logic [CNT_W-1:0]  LAST_TICK = CNT_W'(DELAY_FRAMES - 1);
  // One bit wider than the index so GRID_CELLS == 2**IDX_W does not wrap to 0.
  localparam logic [IDX_W:0]    CELLS_LIM = (IDX_W + 1)'(GRID_CELLS);

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_FILL   = 2'd2;

  typedef enum logic [0:0] {
    S_PICK = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [CELL_W-1:0] val_q, val_n;
  logic [1:0]        mode_q, mode_n;
  logic [GRID_CELLS*CELL_W-1:0] grid_n;
  logic              step_n;
  logic [IDX_W-1:0]  tile_n;

  // Cell view padded to the full index range so any candidate can be looked
  // up safely; padding cells read as empty but are rejected by the range test.
  logic [CELL_W-1:0]     cells [PAD_CELLS];
  logic [GRID_CELLS-1:0] occupied;

  for (genvar i = 0; i < PAD_CELLS; i++) begin : g_cell
    if (i < GRID_CELLS) begin : g_real
      assign cells[i]    = grid[i*CELL_W +: CELL_W];
      assign occupied[i] = |grid[i*CELL_W +: CELL_W];
    end else begin : g_pad
      assign cells[i] = '0;
    end
  end

  logic [1:0]        mode_eff;
  logic              grid_full;
  logic              cand_ok;
  logic [CELL_W-1:0] val_inc;

  assign mode_eff  = (mode == 2'd3) ? MODE_SINGLE : mode;
  assign grid_full = &occupied;
  assign cand_ok   = ({1'b0, lfsr_in} < CELLS_LIM) && (cells[lfsr_in] == '0);
  assign val_inc   = (val_q == TILE_V) ? VAL_ONE : val_q + VAL_ONE;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_PICK;
      cnt      <= '0;
      val_q    <= VAL_ONE;
      mode_q   <= MODE_SINGLE;
      grid     <= '0;
      step     <= 1'b0;
      tile_idx <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      val_q    <= val_n;
      mode_q   <= mode_n;
      grid     <= grid_n;
      step     <= step_n;
      tile_idx <= tile_n;
    end
  end

  // Next-state logic: restart (disable or mode change) overrides any placement.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    val_n   = val_q;
    mode_n  = mode_eff;
    grid_n  = grid;
    step_n  = 1'b0;
    tile_n  = tile_idx;
    if (!enable || (mode_eff != mode_q)) begin
      state_n = S_PICK;
      cnt_n   = '0;
      val_n   = VAL_ONE;
      grid_n  = '0;
    end else begin
      case (state)
        S_PICK: begin
          if ((mode_q == MODE_FILL) && grid_full) begin
            grid_n  = '0;
            step_n  = 1'b1;
            state_n = S_WAIT;
            cnt_n   = '0;
          end else if (cand_ok) begin
            if (mode_q != MODE_FILL) grid_n = '0;
            for (int i = 0; i < GRID_CELLS; i++) begin
              if (IDX_W'(i) == lfsr_in)
                grid_n[i*CELL_W +: CELL_W] = (mode_q == MODE_SINGLE) ? TILE_V : val_q;
            end
            if (mode_q != MODE_SINGLE) val_n = val_inc;
            tile_n  = lfsr_in;
            step_n  = 1'b1;
            state_n = S_WAIT;
            cnt_n   = '0;
          end
        end
        default: begin
          if (frame_tick) begin
            if (cnt == LAST_TICK) state_n = S_PICK;
            else                  cnt_n   = cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_attract_screen.sv
`default_nettype none
// ============================================================================
// Module   : tb_attract_screen
// Purpose  : Directed self-checking bench for attract_screen. Three instances
//            with different parameter sets share clock, reset and controls.
// Revision : 1.0 - initial release
// ============================================================================
module tb_attract_screen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  mode;
  logic        frame_tick;
  logic [3:0]  lfsr_a, lfsr_b;
  logic [1:0]  lfsr_c;
  logic [63:0] grid_a;
  logic [47:0] grid_b;
  logic [15:0] grid_c;
  logic        step_a, step_b, step_c;
  logic [3:0]  tile_a, tile_b;
  logic [1:0]  tile_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Default parameters: 16 cells, 30 frames, tile value 11.
  attract_screen dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .frame_tick(frame_tick), .lfsr_in(lfsr_a),
    .grid(grid_a), .step(step_a), .tile_idx(tile_a)
  );

  // 12 cells, 1 frame delay, max value 3.
  attract_screen #(.GRID_CELLS(12), .CELL_W(4), .DELAY_FRAMES(1), .TILE_VALUE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .frame_tick(frame_tick), .lfsr_in(lfsr_b),
    .grid(grid_b), .step(step_b), .tile_idx(tile_b)
  );

  // 4 cells, 1 frame delay, max value 11.
  attract_screen #(.GRID_CELLS(4), .CELL_W(4), .DELAY_FRAMES(1), .TILE_VALUE(11)) dut_c (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .frame_tick(frame_tick), .lfsr_in(lfsr_c),
    .grid(grid_c), .step(step_c), .tile_idx(tile_c)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int steps;
    int          lf_b  [5] = '{0, 1, 2, 4, 5};
    logic [47:0] exp_b [5] = '{48'h1, 48'h20, 48'h300, 48'h1_0000, 48'h20_0000};
    int          lf_c  [6] = '{0, 1, 2, 3, 0, 0};
    logic [15:0] exp_c [6] = '{16'h0001, 16'h0021, 16'h0321, 16'h4321, 16'h0000, 16'h0005};
    int          til_c [6] = '{0, 1, 2, 3, 3, 0};

    rst_n = 1'b0; enable = 1'b1; mode = 2'd0; frame_tick = 1'b0;
    lfsr_a = 4'd5; lfsr_b = 4'd14; lfsr_c = 2'd0;
    tick(); tick();
    check("reset_grid", grid_a, 64'h0);
    check("reset_step", step_a, 64'h0);
    check("reset_tile", tile_a, 64'h0);

    // Single mode: first placement right after reset.
    rst_n = 1'b1;
    tick();
    check("single_first_grid", grid_a, 64'h0000_0000_00B0_0000);
    check("single_first_step", step_a, 64'h1);
    check("single_first_tile", tile_a, 64'd5);

    steps = 0;
    for (int k = 0; k < 29; k++) begin
      frame_tick = 1'b1; tick(); steps += int'(step_a);
      frame_tick = 1'b0; tick(); steps += int'(step_a);
    end
    check("single_no_early_step", steps, 0);
    frame_tick = 1'b1; tick();
    check("single_30th_tick_step", step_a, 64'h0);

    // Now in PICK: occupied cell 5 is rejected while frame_tick stays high.
    steps = 0;
    for (int k = 0; k < 4; k++) begin
      tick(); steps += int'(step_a);
    end
    check("single_reject_occupied", steps, 0);
    check("single_reject_grid", grid_a, 64'h0000_0000_00B0_0000);
    lfsr_a = 4'd9;
    tick();
    check("single_hop_grid", grid_a, 64'h0000_00B0_0000_0000);
    check("single_hop_tile", tile_a, 64'd9);
    check("single_hop_step", step_a, 64'h1);
    frame_tick = 1'b0;

    // Exactly DELAY_FRAMES ticks before the next step.
    lfsr_a = 4'd3;
    steps = 0;
    for (int k = 0; k < 29; k++) begin
      frame_tick = 1'b1; tick(); steps += int'(step_a);
      frame_tick = 1'b0; tick(); steps += int'(step_a);
    end
    frame_tick = 1'b1; tick(); steps += int'(step_a);
    frame_tick = 1'b0;
    check("delay_no_early_step", steps, 0);
    tick();
    check("delay_step", step_a, 64'h1);
    check("delay_grid", grid_a, 64'h0000_0000_0000_B000);

    // Mid-WAIT mode change restarts without a step.
    mode = 2'd2; lfsr_a = 4'd7;
    tick();
    check("restart_grid", grid_a, 64'h0);
    check("restart_step", step_a, 64'h0);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("disable_grid", grid_a, 64'h0);
      check("disable_step", step_a, 64'h0);
    end
    enable = 1'b1;
    tick();
    check("reenable_grid", grid_a, 64'h0000_0000_1000_0000);
    check("reenable_tile", tile_a, 64'd7);
    check("reenable_step", step_a, 64'h1);
    rst_n = 1'b0;
    tick();
    check("midrun_reset_grid", grid_a, 64'h0);
    check("midrun_reset_tile", tile_a, 64'h0);

    // Out-of-range candidates on a 12-cell grid.
    mode = 2'd0; lfsr_b = 4'd14;
    tick();
    rst_n = 1'b1;
    tick();
    check("range_14_step", step_b, 64'h0);
    check("range_14_grid", grid_b, 64'h0);
    lfsr_b = 4'd15;
    tick();
    check("range_15_step", step_b, 64'h0);
    check("range_15_grid", grid_b, 64'h0);
    lfsr_b = 4'd3;
    tick();
    check("range_3_grid", grid_b, 64'h3000);
    check("range_3_step", step_b, 64'h1);
    check("range_3_tile", tile_b, 64'd3);

    // Count mode with wrap at 3.
    mode = 2'd1; lfsr_b = 4'd14;
    tick();
    check("count_restart_grid", grid_b, 64'h0);
    check("count_restart_step", step_b, 64'h0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        frame_tick = 1'b1; tick();
        check("count_gap_step", step_b, 64'h0);
        frame_tick = 1'b0;
      end
      lfsr_b = 4'(lf_b[k]);
      tick();
      check($sformatf("count_grid_%0d", k), grid_b, exp_b[k]);
      check($sformatf("count_step_%0d", k), step_b, 64'h1);
    end

    // Fill mode on a 4-cell grid: fill, clear, restart fill.
    rst_n = 1'b0; mode = 2'd2; lfsr_c = 2'd0;
    tick();
    rst_n = 1'b1;
    tick();
    check("fill_restart_step", step_c, 64'h0);
    check("fill_restart_grid", grid_c, 64'h0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        frame_tick = 1'b1; tick();
        check("fill_gap_step", step_c, 64'h0);
        frame_tick = 1'b0;
      end
      lfsr_c = 2'(lf_c[k]);
      tick();
      check($sformatf("fill_grid_%0d", k), grid_c, exp_c[k]);
      check($sformatf("fill_step_%0d", k), step_c, 64'h1);
      check($sformatf("fill_tile_%0d", k), tile_c, 64'(til_c[k]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
